// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked multicycle adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} adder_seq_state_e;

  // Counter width for n steps; a single-step sequence still needs one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice shared by every sequencing step.
module adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/multicycle_adder_ctrl.sv
// Computes a WIDTH-bit a + b + cin by stepping one CHUNK-bit slice over
// WIDTH/CHUNK cycles, carrying between steps in a register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for operands; s/cout hold the previous result
// RUN   | one chunk per cycle, low chunk first
// DONE  | result valid, waiting for the sink handshake
module multicycle_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("multicycle_adder_ctrl: WIDTH must be a multiple of CHUNK");
  end

  adder_seq_state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_c;
  logic             accept;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign accept    = in_valid && in_ready;

  // Select the operand chunks addressed by the step counter.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (int'(cnt_q) == i) begin
        slice_a = a_q[i*CHUNK +: CHUNK];
        slice_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .s   (slice_s),
    .cout(slice_c)
  );

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          s_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (int'(cnt_q) == i) s_d[i*CHUNK +: CHUNK] = slice_s;
        end
        carry_d = slice_c;
        if (cnt_q == LAST) begin
          cout_d  = slice_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Self-checking bench: CHUNK=8 and CHUNK=32 instances share one stimulus
// stream and are each compared every cycle with a timeline model.
module tb_multicycle_adder_ctrl;

  localparam int NC [2] = '{4, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        in_ready  [2];
  logic        out_valid [2];
  logic        cout_o    [2];
  logic        busy      [2];
  logic [31:0] s_o       [2];

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_busy  [2] = '{0, 0};
  bit          m_ov    [2] = '{0, 0};
  bit          m_known [2] = '{1, 1};
  int          m_age   [2] = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  logic [32:0] m_exp   [2] = '{33'd0, 33'd0};
  logic [32:0] m_res   [2] = '{33'd0, 33'd0};

  always #5 clk = ~clk;

  multicycle_adder_ctrl #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid[0]), .out_ready(out_ready),
    .s(s_o[0]), .cout(cout_o[0]), .busy(busy[0])
  );

  multicycle_adder_ctrl #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid[1]), .out_ready(out_ready),
    .s(s_o[1]), .cout(cout_o[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted operation is busy until its handshake, and its result
  // {cout,s} = a+b+cin appears exactly NCHUNK edges after the accept edge.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_ov[k] = 0; m_res[k] = '0; m_known[k] = 1;
      end else if (!m_busy[k]) begin
        if (in_valid) begin
          m_busy[k]  = 1;
          m_age[k]   = 0;
          m_exp[k]   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
          m_known[k] = 0;
        end
      end else if (!m_ov[k]) begin
        m_age[k]++;
        if (m_age[k] == NC[k]) begin
          m_ov[k] = 1; m_res[k] = m_exp[k]; m_known[k] = 1;
        end
      end else if (out_ready) begin
        m_ov[k] = 0; m_busy[k] = 0; done_cnt[k]++;
      end
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k), {32'd0, in_ready[k]}, {32'd0, !m_busy[k] && !rst});
      chk($sformatf("out_valid[%0d]", k), {32'd0, out_valid[k]}, {32'd0, m_ov[k]});
      chk($sformatf("busy[%0d]", k), {32'd0, busy[k]}, {32'd0, m_busy[k]});
      if (m_known[k]) chk($sformatf("result[%0d]", k), {cout_o[k], s_o[k]}, m_res[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic accept0(input logic [31:0] aa, input logic [31:0] bb, input logic cc);
    a = aa; b = bb; cin = cc; in_valid = 1'b1;
    for (int g = 0; g < 50 && in_ready[0] !== 1'b1; g++) tick();
    chk("accept_ready", {32'd0, in_ready[0]}, 33'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid[0] !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  int lat;

  initial begin
    // Reset held with a pending request
    rst = 1'b1; in_valid = 1'b1; a = '1; b = '1; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", {32'd0, in_ready[0]}, 33'd0);
      chk("rst_out_valid", {32'd0, out_valid[0]}, 33'd0);
      chk("rst_busy", {32'd0, busy[0]}, 33'd0);
      chk("rst_result", {cout_o[0], s_o[0]}, 33'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_in_ready", {32'd0, in_ready[0]}, 33'd1);

    // Carry ripples through every chunk
    out_ready = 1'b0;
    accept0(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_out(lat);
    chk("ripple_latency", 33'(lat), 33'd4);
    chk("ripple_result", {cout_o[0], s_o[0]}, {1'b1, 32'h0000_0000});
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Backpressure: result held for 5 cycles
    accept0(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_out(lat);
    chk("bp_latency", 33'(lat), 33'd4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {32'd0, out_valid[0]}, 33'd1);
      chk("bp_result", {cout_o[0], s_o[0]}, {1'b0, 32'h2345_6789});
      chk("bp_in_ready", {32'd0, in_ready[0]}, 33'd0);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp_idle_busy", {32'd0, busy[0]}, 33'd0);
    chk("bp_idle_in_ready", {32'd0, in_ready[0]}, 33'd1);

    // Request held while busy; early out_ready has no effect
    out_ready = 1'b1;
    accept0(32'h8000_0000, 32'h8000_0000, 1'b0);
    a = 32'h1; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
    wait_out(lat);
    chk("busy_req_latency", 33'(lat), 33'd4);
    chk("busy_req_result1", {cout_o[0], s_o[0]}, {1'b1, 32'h0});
    tick();
    chk("busy_req_idle", {32'd0, in_ready[0]}, 33'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    wait_out(lat);
    chk("busy_req_latency2", 33'(lat), 33'd4);
    chk("busy_req_result2", {cout_o[0], s_o[0]}, {1'b0, 32'h2});
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Reset after two RUN cycles aborts the operation
    accept0(32'hDEAD_BEEF, 32'h0102_0304, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", {32'd0, busy[0]}, 33'd0);
    chk("abort_result", {cout_o[0], s_o[0]}, 33'd0);
    chk("abort_out_valid", {32'd0, out_valid[0]}, 33'd0);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_valid", {32'd0, out_valid[0]}, 33'd0);
    end

    // Random regression on both instances
    done_cnt[0] = 0; done_cnt[1] = 0;
    for (int cyc = 0; cyc < 60000 && (done_cnt[0] < 1000 || done_cnt[1] < 1000); cyc++) begin
      case ($urandom_range(0, 3))
        0: begin a = 32'hFFFF_FFFF; b = $urandom; end
        1: begin a = $urandom; b = ~a; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      cin       = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    chk("random_budget", {32'd0, done_cnt[0] >= 1000 && done_cnt[1] >= 1000}, 33'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
